// File: rtl/bus_xfer_controller.sv
// bus_xfer_controller: block mover between ROM, RAM, switch buffer and LED latch on the lab bus.
// Ports:
//   clk, n_reset        rising-edge clock, asynchronous active-low reset
//   start, func, len    request pulse, transfer function, word count minus one (sampled in IDLE)
//   src_addr, dst_addr  source start address (ROM or RAM), RAM destination start address
//   ready               (XFER_WAIT_EN builds only) DRIVE holds until ready is high
//   ROMO, RAMO, SWBEN   source output enables onto the bus
//   RAMW, LEDLTCH       destination write strobes
//   rom_addr, ram_addr  current memory addresses, auto-incremented per word
//   busy, done          transfer in progress / final-cycle pulse
// Optional feature: define XFER_WAIT_EN to add the ready handshake on DRIVE.
module bus_xfer_controller #(
    parameter int ADDR_W = 4,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              start,
    input  logic [2:0]        func,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
`ifdef XFER_WAIT_EN
    input  logic              ready,
`endif
    output logic              ROMO,
    output logic              RAMO,
    output logic              SWBEN,
    output logic              RAMW,
    output logic              LEDLTCH,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, DRIVE, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        func_q, func_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] rom_q, rom_d;
    logic [ADDR_W-1:0] ram_q, ram_d;
    logic              drive_go;
    logic              src_on, rom_src, ram_src, sw_src, ram_dst, led_dst;

`ifdef XFER_WAIT_EN
    assign drive_go = ready;
`else
    assign drive_go = 1'b1;
`endif

    // Source/destination decode from the latched function only, so outputs stay Moore.
    assign rom_src = func_q inside {3'd0, 3'd4, 3'd6};
    assign ram_src = func_q inside {3'd1, 3'd7};
    assign sw_src  = func_q inside {3'd2, 3'd3, 3'd5};
    assign ram_dst = func_q inside {3'd3, 3'd4};
    assign led_dst = func_q inside {3'd5, 3'd6, 3'd7};
    assign src_on  = (state_q == DRIVE) || (state_q == WRITE);

    assign ROMO     = src_on && rom_src;
    assign RAMO     = src_on && ram_src;
    assign SWBEN    = src_on && sw_src;
    assign RAMW     = (state_q == WRITE) && ram_dst;
    assign LEDLTCH  = (state_q == WRITE) && led_dst;
    assign busy     = state_q != IDLE;
    assign done     = state_q == DONE;
    assign rom_addr = rom_q;
    assign ram_addr = ram_q;

    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        count_d = count_q;
        rom_d   = rom_q;
        ram_d   = ram_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = DRIVE;
                func_d  = func;
                count_d = len;
                rom_d   = src_addr;
                // RAM pointer is loaded only by functions that touch RAM.
                if (func == 3'd3 || func == 3'd4) ram_d = dst_addr;
                else if (func == 3'd1 || func == 3'd7) ram_d = src_addr;
            end
            DRIVE: state_d = drive_go ? WRITE : DRIVE;
            WRITE: if (count_q == '0) begin
                state_d = DONE;
            end else begin
                state_d = DRIVE;
                count_d = count_q - LEN_W'(1);
                rom_d   = rom_src ? rom_q + ADDR_W'(1) : rom_q;
                ram_d   = (ram_src || ram_dst) ? ram_q + ADDR_W'(1) : ram_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            func_q  <= '0;
            count_q <= '0;
            rom_q   <= '0;
            ram_q   <= '0;
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            count_q <= count_d;
            rom_q   <= rom_d;
            ram_q   <= ram_d;
        end
    end
endmodule
